// File: rtl/ba1533_pkg.sv
// rtl/ba1533_pkg.sv - shared types and default dividers for the BA1533 transmit controller
//
// Purpose: FSM state enums and default clock dividers used by ba1533_uart_rx and ba1533_tx.
// Ports:   none (package).

package ba1533_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int DEF_BAUD_DIV = 434;         // 50 MHz / 115200
  localparam int DEF_BIT_DIV  = 50;          // 1 Mb/s at 50 MHz
  localparam int DEF_HB_DIV   = 25_000_000;  // heartbeat half-period
  localparam int DEF_ACT_HOLD = 2_500_000;   // activity LED hold time

endpackage

// File: rtl/ba1533_uart_rx.sv
// rtl/ba1533_uart_rx.sv - 8N1 UART receiver with input synchronizer
//
// Purpose: synchronizes the asynchronous RX line, detects start edges, samples
//          8 data bits LSB-first at mid-bit and checks the stop bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rxd_i       : raw serial input, idle high
//   rx_byte     : received byte, stable while rx_valid is high
//   rx_valid    : 1-cycle pulse for a byte with a good stop bit
//   frame_err   : 1-cycle pulse when the stop bit is sampled low

module ba1533_uart_rx
  import ba1533_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_q == RX_STOP) && (cnt_q == CNT_LAST) && sync2_q;
    err_d   = (state_q == RX_STOP) && (cnt_q == CNT_LAST) && !sync2_q;
  end

  assign rx_byte   = shreg_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ba1533_tx.sv
// rtl/ba1533_tx.sv - BA1533 transmit controller top: UART echo, bit serializer, LEDs
//
// Purpose: echoes each received UART byte, serializes it MSB-first onto
//          tx_bit_data and drives activity/busy/error/heartbeat LEDs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   UART_RXD    : serial input from host, 8N1, idle high
//   UART_TXD    : serial echo output, 8N1, idle high
//   tx_bit_data : serialized payload, idle low
//   led1..led4  : RX activity, serializer busy, sticky error, heartbeat

module ba1533_tx
  import ba1533_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int BIT_DIV  = DEF_BIT_DIV,
  parameter int HB_DIV   = DEF_HB_DIV,
  parameter int ACT_HOLD = DEF_ACT_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic UART_RXD,
  output logic UART_TXD,
  output logic tx_bit_data,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4
);

  localparam int             BCW       = $clog2(BAUD_DIV);
  localparam int             SCW       = $clog2(BIT_DIV);
  localparam int             HCW       = $clog2(HB_DIV);
  localparam int             ACW       = $clog2(ACT_HOLD);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [SCW-1:0] SER_LAST  = SCW'(BIT_DIV - 1);
  localparam logic [HCW-1:0] HB_LAST   = HCW'(HB_DIV - 1);
  localparam logic [ACW-1:0] ACT_LAST  = ACW'(ACT_HOLD - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  ba1533_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd_i     (UART_RXD),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // ---------------- UART echo transmitter ----------------
  logic           utx_busy_q;
  logic [BCW-1:0] utx_cnt_q;
  logic [3:0]     utx_left_q;   // bits still to send after the current one
  logic [8:0]     utx_sh_q;     // data bits then stop bit, shifted out LSB first
  logic           txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      utx_busy_q <= 1'b0;
      utx_cnt_q  <= '0;
      utx_left_q <= '0;
      utx_sh_q   <= '0;
      txd_q      <= 1'b1;
    end else if (!utx_busy_q) begin
      // A byte arriving while busy is simply not echoed.
      if (rx_valid) begin
        utx_busy_q <= 1'b1;
        utx_cnt_q  <= '0;
        utx_left_q <= 4'd9;
        utx_sh_q   <= {1'b1, rx_byte};
        txd_q      <= 1'b0;
      end
    end else if (utx_cnt_q == BAUD_LAST) begin
      utx_cnt_q <= '0;
      if (utx_left_q == 4'd0) begin
        utx_busy_q <= 1'b0;
      end else begin
        txd_q      <= utx_sh_q[0];
        utx_sh_q   <= {1'b1, utx_sh_q[8:1]};
        utx_left_q <= utx_left_q - 4'd1;
      end
    end else begin
      utx_cnt_q <= utx_cnt_q + BCW'(1);
    end
  end

  // ---------------- Bit serializer ----------------
  ser_state_e     ser_state_q, ser_state_d;
  logic [SCW-1:0] ser_cnt_q, ser_cnt_d;
  logic [2:0]     ser_idx_q, ser_idx_d;
  logic [7:0]     ser_byte_q, ser_byte_d;
  logic           tx_bit_q, tx_bit_d;
  logic           ser_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_state_q <= SER_IDLE;
      ser_cnt_q   <= '0;
      ser_idx_q   <= '0;
      ser_byte_q  <= '0;
      tx_bit_q    <= 1'b0;
    end else begin
      ser_state_q <= ser_state_d;
      ser_cnt_q   <= ser_cnt_d;
      ser_idx_q   <= ser_idx_d;
      ser_byte_q  <= ser_byte_d;
      tx_bit_q    <= tx_bit_d;
    end
  end

  always_comb begin
    ser_state_d = ser_state_q;
    unique case (ser_state_q)
      SER_IDLE:  if (rx_valid) ser_state_d = SER_SHIFT;
      SER_SHIFT: if (ser_cnt_q == SER_LAST && ser_idx_q == 3'd0) ser_state_d = SER_IDLE;
      default:   ser_state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    ser_cnt_d  = ser_cnt_q;
    ser_idx_d  = ser_idx_q;
    ser_byte_d = ser_byte_q;
    tx_bit_d   = tx_bit_q;
    ser_ovf    = 1'b0;
    unique case (ser_state_q)
      SER_IDLE: begin
        tx_bit_d = 1'b0;
        if (rx_valid) begin
          ser_byte_d = rx_byte;
          ser_cnt_d  = '0;
          ser_idx_d  = 3'd7;
          tx_bit_d   = rx_byte[7];
        end
      end
      SER_SHIFT: begin
        // Includes the final cycle of the last bit: a byte then is still dropped.
        ser_ovf = rx_valid;
        if (ser_cnt_q == SER_LAST) begin
          ser_cnt_d = '0;
          if (ser_idx_q == 3'd0) begin
            tx_bit_d = 1'b0;
          end else begin
            ser_idx_d = ser_idx_q - 3'd1;
            tx_bit_d  = ser_byte_q[ser_idx_q - 3'd1];
          end
        end else begin
          ser_cnt_d = ser_cnt_q + SCW'(1);
        end
      end
      default: tx_bit_d = 1'b0;
    endcase
  end

  // ---------------- LEDs ----------------
  logic [HCW-1:0] hb_cnt_q;
  logic           hb_q;
  logic [ACW-1:0] act_cnt_q;
  logic           act_q;
  logic           err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
      act_cnt_q <= '0;
      act_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_q <= '0;
        hb_q     <= ~hb_q;
      end else begin
        hb_cnt_q <= hb_cnt_q + HCW'(1);
      end

      // Down-counter: each new byte reloads the full hold time.
      if (rx_valid) begin
        act_q     <= 1'b1;
        act_cnt_q <= ACT_LAST;
      end else if (act_q) begin
        if (act_cnt_q == '0) act_q <= 1'b0;
        else                 act_cnt_q <= act_cnt_q - ACW'(1);
      end

      if (frame_err || ser_ovf) err_q <= 1'b1;
    end
  end

  assign UART_TXD    = txd_q;
  assign tx_bit_data = tx_bit_q;
  assign led1        = act_q;
  assign led2        = (ser_state_q == SER_SHIFT);
  assign led3        = err_q;
  assign led4        = hb_q;

endmodule

// File: tb/tb_ba1533_tx.sv
// tb/tb_ba1533_tx.sv - self-checking bench for ba1533_tx

module tb_ba1533_tx;

  localparam int BAUD   = 8;
  localparam int BITD   = 4;
  localparam int HB     = 16;
  localparam int ACT    = 20;
  localparam int BITD_B = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rxd_a, rxd_b;
  logic txd_a, bit_a, l1_a, l2_a, l3_a, l4_a;
  logic txd_b, bit_b, l1_b, l2_b, l3_b, l4_b;

  int vectors = 0;
  int miscompares = 0;

  ba1533_tx #(.BAUD_DIV(BAUD), .BIT_DIV(BITD), .HB_DIV(HB), .ACT_HOLD(ACT)) dut (
    .clk(clk), .rst_n(rst_n), .UART_RXD(rxd_a), .UART_TXD(txd_a), .tx_bit_data(bit_a),
    .led1(l1_a), .led2(l2_a), .led3(l3_a), .led4(l4_a)
  );

  ba1533_tx #(.BAUD_DIV(BAUD), .BIT_DIV(BITD_B), .HB_DIV(HB), .ACT_HOLD(ACT)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .UART_RXD(rxd_b), .UART_TXD(txd_b), .tx_bit_data(bit_b),
    .led1(l1_b), .led2(l2_b), .led3(l3_b), .led4(l4_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic led2_of(input int w);
    return (w == 0) ? l2_a : l2_b;
  endfunction
  function automatic logic bit_of(input int w);
    return (w == 0) ? bit_a : bit_b;
  endfunction
  function automatic logic led1_of(input int w);
    return (w == 0) ? l1_a : l1_b;
  endfunction

  task automatic drive(input int w, input logic v);
    if (w == 0) rxd_a = v;
    else        rxd_b = v;
  endtask

  // Host-side 8N1 frame: start 0, data LSB first, chosen stop level.
  task automatic send(input int w, input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(w, fr[i]);
      repeat (BAUD) @(negedge clk);
    end
    drive(w, 1'b1);
  endtask

  // Decode one echoed frame on UART_TXD of instance A at mid-bit points.
  task automatic cap_echo(output logic [7:0] b, output logic ok);
    int t;
    t = 0; ok = 1'b0; b = 8'h00;
    while (txd_a !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) return;
    repeat (BAUD / 2) @(negedge clk);
    if (txd_a !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      b[i] = txd_a;
    end
    repeat (BAUD) @(negedge clk);
    ok = (txd_a === 1'b1);
  endtask

  // Watch one serializer burst; compare every cycle to the MSB-first model.
  task automatic cap_ser(input int w, input logic [7:0] exp, output int len, output int bad,
                         output logic txd0, output int l1cnt);
    int div, t;
    div = (w == 0) ? BITD : BITD_B;
    t = 0; len = 0; bad = 0; txd0 = 1'b1; l1cnt = 0;
    while (!led2_of(w) && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) begin len = -1; return; end
    txd0 = (w == 0) ? txd_a : txd_b;
    while (led2_of(w) && len < 1000) begin
      if (len < 8 * div) begin
        if (bit_of(w) !== exp[7 - (len / div)]) bad++;
      end else begin
        bad++;
      end
      if (led1_of(w)) l1cnt++;
      len++;
      @(negedge clk);
    end
    if (bit_of(w) !== 1'b0) bad++;
  endtask

  task automatic watch_quiet(input int n, output int act);
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || l2_a !== 1'b0 || l1_a !== 1'b0 || bit_a !== 1'b0) act++;
    end
  endtask

  task automatic run_byte(input logic [7:0] d);
    logic [7:0] eb;
    logic       eok, txd0;
    int         len, bad, l1c;
    fork
      send(0, d, 1'b1);
      cap_echo(eb, eok);
      cap_ser(0, d, len, bad, txd0, l1c);
    join
    chk("echo_frame", 32'(eok), 32'd1);
    chk("echo_byte", 32'(eb), 32'(d));
    chk("ser_len", 32'(len), 32'(8 * BITD));
    chk("ser_bits_bad", 32'(bad), 32'd0);
    chk("echo_start_with_ser", 32'(txd0), 32'd0);
    chk("led1_hold", 32'(l1c), 32'(ACT));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       prev4;
    int         toggles, hb_bad, act, len, bad, l1c, t, l2cnt;
    logic       txd0;

    rxd_a = 1'b1; rxd_b = 1'b1; rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_a", 32'({txd_a, bit_a, l1_a, l2_a, l3_a, l4_a}), 32'b100000);
    chk("reset_b", 32'({txd_b, bit_b, l1_b, l2_b, l3_b, l4_b}), 32'b100000);
    rst_n = 1'b1;

    // Heartbeat: a toggle lands on every 16th clock after release.
    toggles = 0; hb_bad = 0; prev4 = l4_a;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (l4_a !== prev4) begin
        toggles++;
        if (c % HB != 0) hb_bad++;
        prev4 = l4_a;
      end
    end
    chk("hb_toggles", 32'(toggles), 32'(64 / HB));
    chk("hb_spacing_bad", 32'(hb_bad), 32'd0);

    // Valid bytes: 0xA5 first, then random.
    for (int k = 0; k < 6; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      run_byte(d);
    end
    chk("no_err_after_valid", 32'(l3_a), 32'd0);

    // Glitch shorter than half a bit.
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    watch_quiet(120, act);
    chk("glitch_activity", 32'(act), 32'd0);
    chk("glitch_no_err", 32'(l3_a), 32'd0);
    run_byte(8'($urandom_range(0, 255)));

    // Framing error: stop bit low.
    fork
      send(0, 8'h3C, 1'b0);
      watch_quiet(110, act);
    join
    chk("frame_activity", 32'(act), 32'd0);
    chk("frame_led3", 32'(l3_a), 32'd1);
    repeat (50) @(negedge clk);
    chk("frame_led3_sticky", 32'(l3_a), 32'd1);

    // Overflow on the slow-serializer instance: second byte arrives mid-shift.
    chk("ovf_pre_led3", 32'(l3_b), 32'd0);
    fork
      begin
        send(1, 8'h11, 1'b1);
        send(1, 8'h22, 1'b1);
      end
      cap_ser(1, 8'h11, len, bad, txd0, l1c);
    join
    chk("ovf_ser_len", 32'(len), 32'(8 * BITD_B));
    chk("ovf_ser_bits_bad", 32'(bad), 32'd0);
    l2cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (l2_b !== 1'b0) l2cnt++;
    end
    chk("ovf_no_second_burst", 32'(l2cnt), 32'd0);
    chk("ovf_led3", 32'(l3_b), 32'd1);

    // Reset asserted during bit 3 of the serializer.
    d = 8'($urandom_range(0, 255));
    fork
      send(0, d, 1'b1);
      begin
        t = 0;
        while (!l2_a && t < 400) begin @(negedge clk); t++; end
        repeat (4 * BITD + 1) @(negedge clk);
        chk("mid_in_bit3", 32'(bit_a), 32'(d[3]));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_txbit", 32'(bit_a), 32'd0);
        chk("mid_reset_led2", 32'(l2_a), 32'd0);
        chk("mid_reset_txd", 32'(txd_a), 32'd1);
        chk("mid_reset_led3", 32'(l3_a), 32'd0);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_byte(8'($urandom_range(0, 255)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
